// File: rtl/pipeline_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : rv32i_types (package)
// Description : Shared types for the RV32I pipeline control logic: control
//               FSM state encoding and the bundle of stage-control outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_types;

    // Pipeline control FSM: SQUASH means the next instruction-memory response
    // belongs to a fetch that was overtaken by a redirect and must be dropped.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } ctrl_state_t;

    // Write enables and bubble selects for the PC and the stage registers.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_bubble;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : pipeline_ctrl_if
// Description : Hazard/redirect/memory-handshake inputs and stage-control
//               outputs of the central pipeline controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use_stall;
    logic             br_taken;
    logic             imem_req;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_bubble;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Controller side: consumes requests, drives stage controls and counters.
    modport master (
        input  load_use_stall, br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_bubble, id_ex_bubble, mem_wb_bubble,
        output stall_cnt, flush_cnt
    );

    // Datapath side: raises requests, obeys stage controls.
    modport slave (
        output load_use_stall, br_taken, imem_req, imem_resp, dmem_req, dmem_resp,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_bubble, id_ex_bubble, mem_wb_bubble,
        input  stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic      [W-1:0] count
);
    logic [W-1:0] r_count;

    // Increment on request unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_ctrl
// Description : Central stall/flush control for the 5-stage RV32I pipeline.
//               Prioritises memory freeze, redirect, stale-fetch squash,
//               load-use stall and fetch wait; keeps stall/flush counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipeline_ctrl_if.master bus
);
    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    stage_ctrl_t      w_ctrl;
    logic             w_dmem_wait;
    logic             w_imem_wait;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_dmem_wait = bus.dmem_req & ~bus.dmem_resp;
    assign w_imem_wait = bus.imem_req & ~bus.imem_resp;

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority-ordered stage controls and next state; first matching case wins.
    always_comb begin
        w_ctrl      = '0;
        w_state_nxt = r_state;
        w_flush_inc = 1'b0;
        if (rst) begin
            w_state_nxt = RUN;
        end else if (w_dmem_wait) begin
            // Freeze: only drain a bubble into WB. A stale fetch response can
            // still arrive and is consumed even while frozen.
            w_ctrl.mem_wb_we     = 1'b1;
            w_ctrl.mem_wb_bubble = 1'b1;
            if ((r_state == SQUASH) && bus.imem_resp) begin
                w_state_nxt = RUN;
            end
        end else if (bus.br_taken) begin
            w_ctrl.pc_we        = 1'b1;
            w_ctrl.if_id_we     = 1'b1;
            w_ctrl.id_ex_we     = 1'b1;
            w_ctrl.ex_mem_we    = 1'b1;
            w_ctrl.mem_wb_we    = 1'b1;
            w_ctrl.if_id_bubble = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
            w_flush_inc         = 1'b1;
            w_state_nxt         = w_imem_wait ? SQUASH : RUN;
        end else if (r_state == SQUASH) begin
            w_ctrl.if_id_we     = 1'b1;
            w_ctrl.id_ex_we     = 1'b1;
            w_ctrl.ex_mem_we    = 1'b1;
            w_ctrl.mem_wb_we    = 1'b1;
            w_ctrl.if_id_bubble = 1'b1;
            if (bus.imem_resp) begin
                w_state_nxt = RUN;
            end
        end else if (bus.load_use_stall) begin
            w_ctrl.id_ex_we     = 1'b1;
            w_ctrl.ex_mem_we    = 1'b1;
            w_ctrl.mem_wb_we    = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
        end else if (w_imem_wait) begin
            w_ctrl.if_id_we     = 1'b1;
            w_ctrl.id_ex_we     = 1'b1;
            w_ctrl.ex_mem_we    = 1'b1;
            w_ctrl.mem_wb_we    = 1'b1;
            w_ctrl.if_id_bubble = 1'b1;
        end else begin
            w_ctrl.pc_we     = 1'b1;
            w_ctrl.if_id_we  = 1'b1;
            w_ctrl.id_ex_we  = 1'b1;
            w_ctrl.ex_mem_we = 1'b1;
            w_ctrl.mem_wb_we = 1'b1;
        end
    end

    assign w_stall_inc = ~rst & ~w_ctrl.pc_we;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (w_flush_cnt)
    );

    assign bus.pc_we         = w_ctrl.pc_we;
    assign bus.if_id_we      = w_ctrl.if_id_we;
    assign bus.id_ex_we      = w_ctrl.id_ex_we;
    assign bus.ex_mem_we     = w_ctrl.ex_mem_we;
    assign bus.mem_wb_we     = w_ctrl.mem_wb_we;
    assign bus.if_id_bubble  = w_ctrl.if_id_bubble;
    assign bus.id_ex_bubble  = w_ctrl.id_ex_bubble;
    assign bus.mem_wb_bubble = w_ctrl.mem_wb_bubble;
    assign bus.stall_cnt     = w_stall_cnt;
    assign bus.flush_cnt     = w_flush_cnt;
endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Two instances (32-bit
//               and 4-bit counters) share one stimulus stream; a rule-table
//               reference model predicts controls, pending-stale flag and
//               counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic t_lus = 1'b0, t_br = 1'b0, t_ireq = 1'b0, t_iresp = 1'b0, t_dreq = 1'b0, t_dresp = 1'b0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state.
    bit          m_stale;
    longint      m_stall32, m_flush32;
    int          m_stall4, m_flush4;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) if32 ();
    pipeline_ctrl_if #(.CNT_W(4))  if4 ();

    assign if32.load_use_stall = t_lus;
    assign if32.br_taken       = t_br;
    assign if32.imem_req       = t_ireq;
    assign if32.imem_resp      = t_iresp;
    assign if32.dmem_req       = t_dreq;
    assign if32.dmem_resp      = t_dresp;
    assign if4.load_use_stall  = t_lus;
    assign if4.br_taken        = t_br;
    assign if4.imem_req        = t_ireq;
    assign if4.imem_resp       = t_iresp;
    assign if4.dmem_req        = t_dreq;
    assign if4.dmem_resp       = t_dresp;

    pipeline_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(if32));
    pipeline_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc, if_id, id_ex, ex_mem, mem_wb we, if_id/id_ex/mem_wb bubble}
    // from the rule table: freeze > redirect > stale fetch > load-use > fetch wait.
    function automatic logic [7:0] model_ctrl(input bit r, input bit l, input bit b,
                                              input bit iq, input bit is, input bit dq,
                                              input bit ds, input bit stale);
        if (r)            return 8'b00000_000;
        if (dq && !ds)    return 8'b00001_001;
        if (b)            return 8'b11111_110;
        if (stale)        return 8'b01111_100;
        if (l)            return 8'b00111_010;
        if (iq && !is)    return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    // One clock of stimulus: drive, check outputs mid-cycle, advance model.
    task automatic step(input bit r, input bit l, input bit b, input bit iq,
                        input bit is, input bit dq, input bit ds);
        logic [7:0] exp_c;
        logic [7:0] obs_c;
        logic [7:0] obs_c4;
        bit         frozen;
        bit         redirect;
        rst = r; t_lus = l; t_br = b; t_ireq = iq; t_iresp = is; t_dreq = dq; t_dresp = ds;
        @(negedge clk);
        exp_c  = model_ctrl(r, l, b, iq, is, dq, ds, m_stale);
        obs_c  = {if32.pc_we, if32.if_id_we, if32.id_ex_we, if32.ex_mem_we, if32.mem_wb_we,
                  if32.if_id_bubble, if32.id_ex_bubble, if32.mem_wb_bubble};
        obs_c4 = {if4.pc_we, if4.if_id_we, if4.id_ex_we, if4.ex_mem_we, if4.mem_wb_we,
                  if4.if_id_bubble, if4.id_ex_bubble, if4.mem_wb_bubble};
        chk("ctrl32", {24'b0, obs_c}, {24'b0, exp_c});
        chk("ctrl4", {24'b0, obs_c4}, {24'b0, exp_c});
        chk("stall_cnt32", if32.stall_cnt, m_stall32[31:0]);
        chk("flush_cnt32", if32.flush_cnt, m_flush32[31:0]);
        chk("stall_cnt4", {28'b0, if4.stall_cnt}, m_stall4);
        chk("flush_cnt4", {28'b0, if4.flush_cnt}, m_flush4);
        // Advance the model for the coming clock edge.
        frozen   = dq && !ds;
        redirect = !r && !frozen && b;
        if (r) begin
            m_stale = 0;
            m_stall32 = 0; m_flush32 = 0; m_stall4 = 0; m_flush4 = 0;
        end else begin
            if (exp_c[7] == 1'b0) begin
                if (m_stall32 < 64'hFFFF_FFFF) m_stall32++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (redirect) begin
                if (m_flush32 < 64'hFFFF_FFFF) m_flush32++;
                if (m_flush4 < 15) m_flush4++;
                m_stale = iq && !is;
            end else if (m_stale && is) begin
                m_stale = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_stale = 0; m_stall32 = 0; m_flush32 = 0; m_stall4 = 0; m_flush4 = 0;
        // Reset: all controls zero, counters cleared.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Data-memory freeze for three cycles, then completion.
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("stall_after_freeze", if32.stall_cnt, 32'd3);

        // Single load-use stall.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("stall_after_loaduse", if32.stall_cnt, 32'd4);

        // Redirect with outstanding fetch, two squash cycles, stale response.
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_after_squash", if32.flush_cnt, 32'd1);

        // Redirect during freeze is deferred until the freeze lifts.
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back redirects in squash; redirect with the stale response.
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Stale response consumed during a freeze.
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset while squashing.
        step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Saturation of the 4-bit stall counter.
        repeat (18) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("stall4_saturated", {28'b0, if4.stall_cnt}, 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline control for the 5-stage RV32I pipeline. It consumes the load-use stall request from the hazard detector, the EX-stage branch/jump redirect and the instruction/data memory handshakes. It drives write enables and bubble-insert controls for the PC and the four stage registers. It also tracks a stale outstanding fetch across redirects and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- load_use_stall  in  1  load-use stall request from the hazard detector
- br_taken  in  1  EX stage redirects the PC (taken branch, jal, jalr)
- imem_req  in  1  instruction fetch outstanding this cycle
- imem_resp  in  1  instruction memory returns data this cycle
- dmem_req  in  1  MEM stage holds a valid load/store
- dmem_resp  in  1  data memory completes this cycle
- pc_we  out  1  PC register write enable
- if_id_we / id_ex_we / ex_mem_we / mem_wb_we  out  1 each  stage register write enables
- if_id_bubble / id_ex_bubble / mem_wb_bubble  out  1 each  load an invalid (NOP) entry when the matching *_we is high
- stall_cnt  out  CNT_W  cycles with pc_we=0 outside reset, saturating
- flush_cnt  out  CNT_W  accepted redirects, saturating

## Operation
Derived conditions:
- dmem_wait = dmem_req & ~dmem_resp
- imem_wait = imem_req & ~imem_resp

State machine (ctrl_state_t):
- RUN: normal operation.
- SQUASH: a redirect was taken while a fetch was outstanding. The next imem_resp is stale.

Combinational action, evaluated in priority order; the first match wins:
1. rst: all *_we=0, all bubbles=0.
2. dmem_wait (freeze): pc/if_id/id_ex/ex_mem we=0. mem_wb_we=1 with mem_wb_bubble=1. br_taken and load_use_stall are ignored and re-evaluated once unfrozen.
3. br_taken (redirect): pc_we=1; if_id and id_ex load bubbles; ex_mem and mem_wb advance. flush_cnt increments. Next state is SQUASH if imem_wait, otherwise RUN.
4. state==SQUASH: pc_we=0; if_id loads a bubble; the rest advance. On imem_resp the stale word is discarded and the next state is RUN.
5. load_use_stall: pc/if_id we=0; id_ex loads a bubble; ex_mem and mem_wb advance.
6. imem_wait: pc_we=0; if_id loads a bubble; the rest advance.
7. Otherwise: all we=1, all bubbles=0.

SQUASH is left on imem_resp even while a dmem_wait freeze is active. The stale response is consumed regardless of the freeze.

Counters:
- CNT_W-bit, increment by 1, hold at all-ones (no wrap).
- stall_cnt counts every non-reset cycle with pc_we=0.

## Timing
- Stage-control outputs are purely combinational from the inputs and the state register, with zero-cycle latency to the stage registers' next edge.
- The state register and counters update on the rising clk edge.
- Reset values: state RUN, stall_cnt=0, flush_cnt=0. During reset all stage-control outputs are 0.
- Reset in SQUASH returns to RUN immediately. The memory is reset alongside, so no stale response follows.
- A back-to-back br_taken while in SQUASH redirects again. The block stays in SQUASH if the fetch is still outstanding.
- br_taken in the same cycle as the stale imem_resp goes to RUN, because the outstanding fetch has completed.

## Structure
- Add ctrl_state_t (RUN, SQUASH) to the rv32i_types package. Stage-register typedefs are unchanged.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice.

## Test plan
- dmem_req=1, dmem_resp=0 for 3 cycles, then 1 → only mem_wb_we=1 with bubble for 3 cycles, full advance on the 4th; stall_cnt=3.
- load_use_stall=1 for one cycle → pc_we=0, if_id_we=0, id_ex bubble, ex_mem_we=1; stall_cnt +1.
- br_taken with imem_req=1, imem_resp=0 → pc_we=1, state SQUASH. Two cycles later imem_resp=1 → if_id bubble, state RUN; flush_cnt=1.
- br_taken and dmem_wait in the same cycle → freeze only, flush_cnt unchanged. Next cycle, with dmem_resp=1 and br_taken still high → redirect is taken.
- rst asserted while in SQUASH → next cycle state RUN, counters 0, all stage controls 0 while rst is high.
- Force stall_cnt to all-ones (CNT_W=4, 16 stall cycles) → it holds at 15.
